traffic_phase_seq: RTL
======================

Name: traffic_phase_seq

Overview:
- Sequences the intersection's six signal movements (EW left/straight/right, SN left/straight/right) using the six green durations from the key-adjust block.
- Runs each movement as a GREEN → YELLOW → ALL_RED phase, then advances to the next movement.
- Generates its own 1-second tick, exposes a seconds countdown for the display, and supports a hold input and a night flash mode.

Parameters:
- CLK_DIV, 50_000_000, sys_clk cycles per 1-second tick; minimum 2.
- YELLOW_TIME, 3, yellow interval in seconds; 1..63.
- ALL_RED_TIME, 1, all-red clearance in seconds; 1..63.
- MIN_GREEN, 5, lower clamp applied to latched green durations; 1..63.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- ew_left_time  in  6  green seconds for EW left.
- ew_stra_time  in  6  green seconds for EW straight.
- ew_right_time  in  6  green seconds for EW right.
- sn_left_time  in  6  green seconds for SN left.
- sn_stra_time  in  6  green seconds for SN straight.
- sn_right_time  in  6  green seconds for SN right.
- hold  in  1  freezes the countdown while high.
- flash_en  in  1  night flash mode request.
- green  out  6  one-hot movement green; bit order {ew_l, ew_s, ew_r, sn_l, sn_s, sn_r}, bit5 = ew_l.
- yellow  out  6  movement yellow, same bit order.
- countdown  out  6  seconds remaining in the current interval.
- phase_idx  out  3  current movement index, 0..5 (0 = ew_l).
- state  out  2  0 = GREEN, 1 = YELLOW, 2 = ALL_RED, 3 = FLASH.

Behaviour:
- All logic is clocked on sys_clk only; there is no derived clock.
- Tick: counter cnt counts 0..CLK_DIV-1 and wraps. tick is a 1-cycle pulse when cnt == CLK_DIV-1. The counter runs regardless of hold and flash_en.
- Reset (asynchronous, any time, mid-phase included):
  - state = ALL_RED, phase_idx = 5, countdown = ALL_RED_TIME.
  - green = 0, yellow = 0, cnt = 0, flash toggle = 0.
  - The first green after reset is therefore phase 0 (ew_l).
- Countdown: on a tick with hold = 0 and countdown > 1, countdown decrements by 1.
- Transition: on a tick with hold = 0 and countdown == 1, the next interval is loaded on that same edge, with no idle cycle:
  - GREEN → YELLOW; countdown = YELLOW_TIME.
  - YELLOW → ALL_RED; countdown = ALL_RED_TIME.
  - ALL_RED → GREEN; phase_idx = (phase_idx == 5) ? 0 : phase_idx + 1; countdown = max(time[new phase], MIN_GREEN).
- Green durations are sampled only at ALL_RED → GREEN entry. Changes to the time inputs during a phase take effect at the next entry of that movement.
- hold = 1: ticks are ignored; state, phase_idx and countdown are frozen; light outputs are unchanged.
- Outputs are registered and reflect state the cycle after each edge:
  - GREEN: green bit of phase_idx = 1, all else 0.
  - YELLOW: yellow bit of phase_idx = 1, all else 0.
  - ALL_RED: green = 0, yellow = 0.
  - green & yellow is always 0, and at most one green bit is ever set.
- flash_en:
  - Rising level is sampled only in ALL_RED at the end-of-interval tick. At that point state goes to FLASH instead of GREEN, and countdown = 0.
  - In FLASH, each tick toggles the flash bit; yellow = {6{toggle}}, green = 0. hold has no effect in FLASH.
  - FLASH exits on the first tick with flash_en = 0: state = ALL_RED, phase_idx = 5, countdown = ALL_RED_TIME, toggle cleared.
  - This guarantees an all-red clearance before phase 0.
- hold and an end-of-interval tick in the same cycle: hold wins and no transition occurs.
- Full cycle length in seconds = sum of the six clamped greens + 6 × (YELLOW_TIME + ALL_RED_TIME).

Test Plan:
- Reset release, CLK_DIV = 4, all times = 10, YELLOW_TIME = 3, ALL_RED_TIME = 1:
  - After 1 tick (4 clocks): state = GREEN, phase_idx = 0, green = 6'b100000, countdown = 10.
  - After 10 more ticks: state = YELLOW, yellow = 6'b100000, countdown = 3.
- Full rotation, all times = 10: phase_idx steps 0..5 then back to 0 after 6 × 14 = 84 ticks from the first green. Checker asserts green & yellow == 0 and one-hot green on every cycle.
- Latch and clamp:
  - ew_stra_time changed from 10 to 20 during phase 0 → phase 1 green countdown starts at 20.
  - sn_left_time = 2 → phase 3 countdown starts at 5 (MIN_GREEN).
- Hold: assert hold at countdown = 7 in GREEN for 5 ticks → countdown stays 7 and outputs are frozen. After release, countdown decrements on the next tick.
- Flash:
  - flash_en = 1 during phase 2 GREEN → that phase completes YELLOW and ALL_RED, then state = FLASH and yellow toggles 6'h3F / 0 each tick.
  - Drop flash_en → next tick gives ALL_RED for 1 tick, then GREEN phase 0.
- Asynchronous reset mid-YELLOW of phase 4 → outputs clear immediately without waiting for a clock edge; state = ALL_RED, phase_idx = 5, countdown = 1.

Source files
------------

// File: rtl/traffic_phase_seq.sv
// -----------------------------------------------------------------------------
// traffic_phase_seq
//
// Steps through the six signal movements of the intersection
// (EW left/straight/right, then SN left/straight/right).
// Each movement runs GREEN -> YELLOW -> ALL_RED and then hands over to the
// next movement. A 1-second tick is derived from sys_clk by a free-running
// divider. There is no derived clock.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   *_time [5:0]         green seconds per movement; sampled when a movement
//                        enters GREEN and clamped up to MIN_GREEN
//   hold                 freezes the countdown and the lights (ignored in FLASH)
//   flash_en             night flash request; taken at the end of an ALL_RED
//   green/yellow [5:0]   per-movement lamps, bit5 = ew_l ... bit0 = sn_r
//   countdown [5:0]      seconds left in the current interval
//   phase_idx [2:0]      current movement, 0 = ew_l .. 5 = sn_r
//   state [1:0]          0 GREEN, 1 YELLOW, 2 ALL_RED, 3 FLASH
//
// All outputs come straight from flops. The lamp flops are loaded from the
// next-state values, so the lamps always agree with state/phase_idx in the
// same cycle.
// -----------------------------------------------------------------------------
module traffic_phase_seq #(
  parameter int CLK_DIV      = 50_000_000,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int MIN_GREEN    = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] ew_left_time,
  input  logic [5:0] ew_stra_time,
  input  logic [5:0] ew_right_time,
  input  logic [5:0] sn_left_time,
  input  logic [5:0] sn_stra_time,
  input  logic [5:0] sn_right_time,
  input  logic       hold,
  input  logic       flash_en,
  output logic [5:0] green,
  output logic [5:0] yellow,
  output logic [5:0] countdown,
  output logic [2:0] phase_idx,
  output logic [1:0] state
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2,
    ST_FLASH   = 2'd3
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [5:0]       cd_q, cd_d;
  logic             tog_q, tog_d;
  logic [5:0]       green_q, green_d;
  logic [5:0]       yellow_q, yellow_d;

  logic             tick;
  logic [2:0]       phase_inc;
  logic [5:0]       raw_time;
  logic [5:0]       green_time;
  logic [5:0]       lamp_sel;
  logic [5:0]       lamp_msb;

  // One-second tick: the divider never stops, so hold/flash cannot skew it.
  assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  assign phase_inc = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;

  // Green duration of the movement about to start.
  always_comb begin
    raw_time = ew_left_time;
    case (phase_inc)
      3'd0:    raw_time = ew_left_time;
      3'd1:    raw_time = ew_stra_time;
      3'd2:    raw_time = ew_right_time;
      3'd3:    raw_time = sn_left_time;
      3'd4:    raw_time = sn_stra_time;
      3'd5:    raw_time = sn_right_time;
      default: raw_time = ew_left_time;
    endcase
  end

  assign green_time = (raw_time < 6'(MIN_GREEN)) ? 6'(MIN_GREEN) : raw_time;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cd_d    = cd_q;
    tog_d   = tog_q;
    if (tick) begin
      if (state_q == ST_FLASH) begin
        // Flash ignores hold. Leaving flash always passes through ALL_RED
        // with phase 5, so the next green is ew_l after a full clearance.
        if (!flash_en) begin
          state_d = ST_ALL_RED;
          phase_d = 3'd5;
          cd_d    = 6'(ALL_RED_TIME);
          tog_d   = 1'b0;
        end else begin
          tog_d = ~tog_q;
        end
      end else if (!hold) begin
        if (cd_q > 6'd1) begin
          cd_d = cd_q - 6'd1;
        end else begin
          case (state_q)
            ST_GREEN: begin
              state_d = ST_YELLOW;
              cd_d    = 6'(YELLOW_TIME);
            end
            ST_YELLOW: begin
              state_d = ST_ALL_RED;
              cd_d    = 6'(ALL_RED_TIME);
            end
            ST_ALL_RED: begin
              if (flash_en) begin
                state_d = ST_FLASH;
                cd_d    = 6'd0;
                tog_d   = 1'b0;
              end else begin
                state_d = ST_GREEN;
                phase_d = phase_inc;
                cd_d    = green_time;
              end
            end
            default: begin
              state_d = ST_ALL_RED;
              cd_d    = 6'(ALL_RED_TIME);
            end
          endcase
        end
      end
    end
  end

  // Lamp decode from the next state, registered below.
  assign lamp_msb = 6'b100000;
  assign lamp_sel = lamp_msb >> phase_d;

  always_comb begin
    green_d  = 6'd0;
    yellow_d = 6'd0;
    case (state_d)
      ST_GREEN:  green_d  = lamp_sel;
      ST_YELLOW: yellow_d = lamp_sel;
      ST_FLASH:  yellow_d = {6{tog_d}};
      default: begin
        green_d  = 6'd0;
        yellow_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      state_q  <= ST_ALL_RED;
      phase_q  <= 3'd5;
      cd_q     <= 6'(ALL_RED_TIME);
      tog_q    <= 1'b0;
      green_q  <= 6'd0;
      yellow_q <= 6'd0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      cd_q     <= cd_d;
      tog_q    <= tog_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign countdown = cd_q;
  assign phase_idx = phase_q;
  assign state     = state_q;

endmodule
